// File: rtl/axi4lite_read_arbiter.sv
// Two-master AXI4-Lite read arbiter with a registered AR path and an R passthrough.
// Define ARB_IFETCH_PRIO_EN for fixed priority to master 0; round-robin otherwise.
module axi4lite_read_arbiter #(
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic [2:0]            s_arprot,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic                  busy,
  output logic                  grant
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e                  state_q, state_d;
  logic                    s_arvalid_q, s_arvalid_d;
  logic [ADDR_WIDTH-1:0]   s_araddr_q, s_araddr_d;
  logic [2:0]              s_arprot_q, s_arprot_d;
  logic                    grant_q, grant_d;
  logic                    rr_ptr_q, rr_ptr_d;
  logic                    any_req;
  logic                    winner;

  always_comb begin
    any_req = m0_arvalid | m1_arvalid;
`ifdef ARB_IFETCH_PRIO_EN
    // Master 0 wins whenever it requests.
    winner  = ~m0_arvalid;
`else
    if (m0_arvalid && m1_arvalid) begin
      winner = rr_ptr_q;
    end else begin
      winner = m1_arvalid;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req)                state_d = StAddr;
      StAddr:  if (s_arready)              state_d = StData;
      StData:  if (s_rvalid && s_rready)   state_d = StIdle;
      default:                             state_d = StIdle;
    endcase
  end

  always_comb begin
    s_arvalid_d = s_arvalid_q;
    s_araddr_d  = s_araddr_q;
    s_arprot_d  = s_arprot_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    if (state_q == StIdle && any_req) begin
      s_araddr_d  = winner ? m1_araddr : m0_araddr;
      s_arprot_d  = {~winner, 2'b00};
      grant_d     = winner;
      s_arvalid_d = 1'b1;
    end
    if (state_q == StAddr && s_arready) begin
      s_arvalid_d = 1'b0;
    end
    if (state_q == StData && s_rvalid && s_rready) begin
      rr_ptr_d = ~grant_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_arvalid_q <= 1'b0;
      s_araddr_q  <= '0;
      s_arprot_q  <= 3'b000;
      grant_q     <= 1'b0;
      rr_ptr_q    <= 1'b0;
    end else begin
      s_arvalid_q <= s_arvalid_d;
      s_araddr_q  <= s_araddr_d;
      s_arprot_q  <= s_arprot_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  always_comb begin
    m0_arready = (state_q == StIdle) && any_req && !winner;
    m1_arready = (state_q == StIdle) && any_req && winner;
    m0_rvalid  = (state_q == StData) && !grant_q && s_rvalid;
    m1_rvalid  = (state_q == StData) && grant_q && s_rvalid;
    s_rready   = (state_q == StData) && (grant_q ? m1_rready : m0_rready);
    m0_rdata   = s_rdata;
    m0_rresp   = s_rresp;
    m1_rdata   = s_rdata;
    m1_rresp   = s_rresp;
    s_arvalid  = s_arvalid_q;
    s_araddr   = s_araddr_q;
    s_arprot   = s_arprot_q;
    grant      = grant_q;
    busy       = (state_q != StIdle);
  end

endmodule
